// File: rtl/ddr_out_lane_pkg.sv
// Shared types for the DDR4 output-lane delay controller.
package ddr_out_lane_pkg;

  localparam int DEFAULT_TAP_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIR,
    STEP,
    SETTLE,
    DONE
  } state_t;

  // Lane-select width; a single-lane build still needs one bit.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_out_lane_dly_ctrl_if.sv
// Tap-request handshake between a training/calibration master and the lane controller.
interface ddr_out_lane_dly_ctrl_if
  import ddr_out_lane_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int TAP_W     = DEFAULT_TAP_W
);
  localparam int LANE_W = lane_w(NUM_LANES);

  logic              valid;
  logic              ready;
  logic [LANE_W-1:0] lane;
  logic [TAP_W-1:0]  tap;
  logic              load;
  logic              done;
  logic              rsp_err;

  modport master (output valid, lane, tap, load, input ready, done, rsp_err);
  modport slave  (input valid, lane, tap, load, output ready, done, rsp_err);
endinterface

// File: rtl/ddr_out_dly_stepper.sv
// Single shared delay-line stepper: accepts one tap request, sequences LOAD or
// DIR/STEP/SETTLE moves for the captured lane, and reports completion.
module ddr_out_dly_stepper
  import ddr_out_lane_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int LANE_W     = 2,
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 255,
  parameter int SETTLE_CYC = 4
) (
  input  logic              fab_clk,
  input  logic              sync_rst_n,
  input  logic              req_valid,
  input  logic [LANE_W-1:0] req_lane,
  input  logic [TAP_W-1:0]  req_tap,
  input  logic              req_load,
  input  logic [TAP_W-1:0]  cur_tap,
  input  logic              oor,
  output logic              ready,
  output logic              done,
  output logic              rsp_err,
  output logic              move,
  output logic              load,
  output logic              set_sticky,
  output logic              active,
  output logic              dir,
  output logic [LANE_W-1:0] lane
);
  localparam int                CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [TAP_W-1:0]  steps_left;
  logic              err_q, active_q, dir_q;
  logic [LANE_W-1:0] lane_q;
  logic              reject, tap_up, settle_last;

  assign reject      = (32'(req_lane) >= NUM_LANES) || (!req_load && (32'(req_tap) > MAX_TAP));
  assign tap_up      = req_tap > cur_tap;
  assign settle_last = (cnt == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (reject)                 state_nxt = DONE;
          else if (req_load)          state_nxt = LOAD;
          else if (req_tap == cur_tap) state_nxt = DONE;
          else                        state_nxt = DIR;
        end
      end
      LOAD:   state_nxt = DONE;
      DIR:    state_nxt = STEP;
      STEP:   state_nxt = SETTLE;
      SETTLE: begin
        if (settle_last) state_nxt = (oor || steps_left == '0) ? DONE : STEP;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge fab_clk) begin
    if (!sync_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      steps_left <= '0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
      dir_q      <= 1'b0;
      lane_q     <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lane_q     <= req_lane;
            dir_q      <= tap_up;
            steps_left <= tap_up ? (req_tap - cur_tap) : (cur_tap - req_tap);
            err_q      <= reject;
            active_q   <= (state_nxt == DIR);
          end
        end
        STEP: begin
          steps_left <= steps_left - 1'b1;
          cnt        <= CNT_LAST;
        end
        SETTLE: begin
          if (!settle_last) cnt <= cnt - 1'b1;
          else if (oor)     err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready      = (state == IDLE);
  assign done       = (state == DONE);
  assign rsp_err    = (state == DONE) && err_q;
  assign move       = (state == STEP);
  assign load       = (state == LOAD);
  assign set_sticky = (state == SETTLE) && settle_last && oor;
  assign active     = active_q && (state != IDLE);
  assign dir        = dir_q;
  assign lane       = lane_q;

endmodule

// File: rtl/ddr_out_lane_dly_ctrl.sv
// DDR4 output-lane controller: registered TX/OE toward PF_IOD plus a shared TX delay stepper.
// Optional DDR_OUT_DLY_OE_BLANK_EN tristates the lane being stepped from DIR through DONE.
module ddr_out_lane_dly_ctrl
  import ddr_out_lane_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int RATIO      = 4,
  parameter int TAP_W      = DEFAULT_TAP_W,
  parameter int MAX_TAP    = 255,
  parameter int INIT_TAP   = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic                         fab_clk,
  input  logic                         sync_rst_n,
  input  logic [NUM_LANES*RATIO-1:0]   tx_data_in,
  input  logic [NUM_LANES*RATIO-1:0]   oe_data_in,
  output logic [NUM_LANES*RATIO-1:0]   tx_data_out,
  output logic [NUM_LANES*RATIO-1:0]   oe_data_out,
  ddr_out_lane_dly_ctrl_if.slave       dly,
  output logic [NUM_LANES-1:0]         dly_err_sticky,
  output logic [NUM_LANES*TAP_W-1:0]   dly_cur_tap,
  output logic [NUM_LANES-1:0]         delay_line_move,
  output logic [NUM_LANES-1:0]         delay_line_direction,
  output logic [NUM_LANES-1:0]         delay_line_load,
  input  logic [NUM_LANES-1:0]         delay_line_out_of_range
);
  localparam int               LANE_W = lane_w(NUM_LANES);
  localparam logic [TAP_W-1:0] INIT_V = TAP_W'(INIT_TAP);

  logic [NUM_LANES*RATIO-1:0] tx_q, oe_q;
  logic [TAP_W-1:0]           tap_q [NUM_LANES];
  logic [NUM_LANES-1:0]       sticky_q, lane_hot;
  logic [TAP_W-1:0]           cur_req;
  logic                       oor_sel;
  logic                       st_move, st_load, st_sticky, st_active, st_dir;
  logic [LANE_W-1:0]          st_lane;

  always_ff @(posedge fab_clk) begin
    if (!sync_rst_n) begin
      tx_q <= '0;
      oe_q <= '0;
    end else begin
      tx_q <= tx_data_in;
      oe_q <= oe_data_in;
    end
  end

  // Loop-compare muxes keep out-of-range request lanes from indexing past the array.
  always_comb begin
    cur_req  = INIT_V;
    oor_sel  = 1'b0;
    lane_hot = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (32'(dly.lane) == i) cur_req = tap_q[i];
      if (32'(st_lane) == i) begin
        oor_sel     = delay_line_out_of_range[i];
        lane_hot[i] = 1'b1;
      end
    end
  end

  ddr_out_dly_stepper #(
    .NUM_LANES  (NUM_LANES),
    .LANE_W     (LANE_W),
    .TAP_W      (TAP_W),
    .MAX_TAP    (MAX_TAP),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_stepper (
    .fab_clk    (fab_clk),
    .sync_rst_n (sync_rst_n),
    .req_valid  (dly.valid),
    .req_lane   (dly.lane),
    .req_tap    (dly.tap),
    .req_load   (dly.load),
    .cur_tap    (cur_req),
    .oor        (oor_sel),
    .ready      (dly.ready),
    .done       (dly.done),
    .rsp_err    (dly.rsp_err),
    .move       (st_move),
    .load       (st_load),
    .set_sticky (st_sticky),
    .active     (st_active),
    .dir        (st_dir),
    .lane       (st_lane)
  );

  // NOTE: the tap/sticky array is a handful of flops, not a RAM, so it takes the reset like any register.
  always_ff @(posedge fab_clk) begin
    if (!sync_rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= INIT_V;
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_hot[i]) begin
          if (st_move)   tap_q[i] <= st_dir ? tap_q[i] + 1'b1 : tap_q[i] - 1'b1;
          if (st_load) begin
            tap_q[i]    <= INIT_V;
            sticky_q[i] <= 1'b0;
          end
          if (st_sticky) sticky_q[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    dly_cur_tap = '0;
    for (int i = 0; i < NUM_LANES; i++) dly_cur_tap[i*TAP_W +: TAP_W] = tap_q[i];
  end

  assign dly_err_sticky       = sticky_q;
  assign delay_line_move      = st_move ? lane_hot : '0;
  assign delay_line_load      = st_load ? lane_hot : '0;
  assign delay_line_direction = (st_active && st_dir) ? lane_hot : '0;
  assign tx_data_out          = tx_q;

`ifdef DDR_OUT_DLY_OE_BLANK_EN
  logic [NUM_LANES*RATIO-1:0] oe_blank;
  always_comb begin
    oe_blank = '0;
    for (int i = 0; i < NUM_LANES; i++)
      oe_blank[i*RATIO +: RATIO] = {RATIO{lane_hot[i] & st_active}};
  end
  assign oe_data_out = oe_q & ~oe_blank;
`else
  assign oe_data_out = oe_q;
`endif

endmodule

// File: tb/tb_ddr_out_lane_dly_ctrl.sv
// Directed self-checking bench for ddr_out_lane_dly_ctrl (4 lanes, TAP_W=9, SETTLE_CYC=4).
module tb_ddr_out_lane_dly_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tx_in, oe_in, tx_out, oe_out;
  logic [3:0]  sticky, mv_vec, dir_vec, ld_vec, oor_vec;
  logic [35:0] cur;

  logic [2:0]  tx3_in, oe3_in, tx3_out, oe3_out;
  logic [2:0]  sticky3, mv3, dir3, ld3, oor3;
  logic [23:0] cur3;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ddr_out_lane_dly_ctrl_if #(.NUM_LANES(4), .TAP_W(9)) dif ();
  ddr_out_lane_dly_ctrl_if #(.NUM_LANES(3), .TAP_W(8)) dif3 ();

  ddr_out_lane_dly_ctrl #(
    .NUM_LANES(4), .RATIO(4), .TAP_W(9), .MAX_TAP(255), .INIT_TAP(1), .SETTLE_CYC(4)
  ) u_dut (
    .fab_clk(clk), .sync_rst_n(rst_n),
    .tx_data_in(tx_in), .oe_data_in(oe_in), .tx_data_out(tx_out), .oe_data_out(oe_out),
    .dly(dif), .dly_err_sticky(sticky), .dly_cur_tap(cur),
    .delay_line_move(mv_vec), .delay_line_direction(dir_vec), .delay_line_load(ld_vec),
    .delay_line_out_of_range(oor_vec)
  );

  ddr_out_lane_dly_ctrl #(
    .NUM_LANES(3), .RATIO(1), .TAP_W(8), .MAX_TAP(255), .INIT_TAP(1), .SETTLE_CYC(4)
  ) u_dut3 (
    .fab_clk(clk), .sync_rst_n(rst_n),
    .tx_data_in(tx3_in), .oe_data_in(oe3_in), .tx_data_out(tx3_out), .oe_data_out(oe3_out),
    .dly(dif3), .dly_err_sticky(sticky3), .dly_cur_tap(cur3),
    .delay_line_move(mv3), .delay_line_direction(dir3), .delay_line_load(ld3),
    .delay_line_out_of_range(oor3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] tap_of(input int lane);
    return cur[lane*9 +: 9];
  endfunction

  // Issues one request and watches the lane until DONE (bounded), then returns to IDLE.
  task automatic run_req(input int lane, input int tap, input bit load, input int oor_after,
                         output int done_cyc, output int mv_cnt, output logic [3:0] mv_or,
                         output logic [3:0] ld_or, output int first_mv, output int last_mv,
                         output logic [3:0] dir_k1, output logic [15:0] oe_k1, output logic err);
    done_cyc = -1; mv_cnt = 0; mv_or = '0; ld_or = '0;
    first_mv = -1; last_mv = -1; dir_k1 = '0; oe_k1 = '0; err = 1'b0;
    dif.valid = 1'b1;
    dif.lane  = lane[1:0];
    dif.tap   = tap[8:0];
    dif.load  = load;
    tick();
    dif.valid = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      if (dif.done) begin
        done_cyc = k;
        err      = dif.rsp_err;
        break;
      end
      if (k == 1) begin
        dir_k1 = dir_vec;
        oe_k1  = oe_out;
      end
      if (mv_vec != '0) begin
        mv_cnt++;
        if (first_mv < 0) first_mv = k;
        last_mv = k;
        if (mv_cnt == oor_after) oor_vec[lane] = 1'b1;
      end
      mv_or = mv_or | mv_vec;
      ld_or = ld_or | ld_vec;
      tick();
    end
    if (done_cyc >= 0) tick();
  endtask

  int          dc, mc, fm, lm;
  logic [3:0]  mo, lo, d1;
  logic [15:0] o1;
  logic        er;
  logic        done_seen;

  initial begin
    rst_n = 1'b0;
    tx_in = 16'hA5C3; oe_in = 16'hFFFF; oor_vec = '0;
    tx3_in = '0; oe3_in = '0; oor3 = '0;
    dif.valid = 1'b0; dif.lane = '0; dif.tap = '0; dif.load = 1'b0;
    dif3.valid = 1'b0; dif3.lane = '0; dif3.tap = '0; dif3.load = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_oe", oe_out, 16'h0000);
    check("rst_tx", tx_out, 16'h0000);
    check("rst_ready", dif.ready, 1'b1);
    check("rst_taps", cur, {4{9'd1}});
    check("rst_iod", {mv_vec, dir_vec, ld_vec, sticky, dif.done, dif.rsp_err}, 18'h0);

    // Data path: one-cycle registered copy
    rst_n = 1'b1;
    tick();
    check("dp_tx0", tx_out, 16'hA5C3);
    check("dp_oe0", oe_out, 16'hFFFF);
    tx_in = 16'h3C5A; oe_in = 16'h0F0F;
    check("dp_tx_hold", tx_out, 16'hA5C3);
    tick();
    check("dp_tx1", tx_out, 16'h3C5A);
    check("dp_oe1", oe_out, 16'h0F0F);
    oe_in = 16'hFFFF;
    tick();

    // Lane 2: 1 -> 4, three increments
    run_req(2, 4, 1'b0, 0, dc, mc, mo, lo, fm, lm, d1, o1, er);
    check("l2_done_cyc", dc, 17);
    check("l2_moves", mc, 3);
    check("l2_move_lane", mo, 4'b0100);
    check("l2_first_move", fm, 2);
    check("l2_last_move", lm, 12);
    check("l2_dir", d1, 4'b0100);
    check("l2_no_load", lo, 4'b0000);
    check("l2_err", er, 1'b0);
    check("l2_tap", tap_of(2), 9'd4);
    check("l2_ready", dif.ready, 1'b1);
`ifdef DDR_OUT_DLY_OE_BLANK_EN
    check("l2_oe_blank", o1, 16'hF0FF);
`else
    check("l2_oe_blank", o1, 16'hFFFF);
`endif

    // Lane 0: 1 -> 4, then 4 -> 2
    run_req(0, 4, 1'b0, 0, dc, mc, mo, lo, fm, lm, d1, o1, er);
    check("l0_up_tap", tap_of(0), 9'd4);
    run_req(0, 2, 1'b0, 0, dc, mc, mo, lo, fm, lm, d1, o1, er);
    check("l0_dn_done_cyc", dc, 12);
    check("l0_dn_moves", mc, 2);
    check("l0_dn_lane", mo, 4'b0001);
    check("l0_dn_dir", d1, 4'b0000);
    check("l0_dn_err", er, 1'b0);
    check("l0_dn_tap", tap_of(0), 9'd2);

    // Lane 1: out-of-range after 2nd move
    run_req(1, 6, 1'b0, 2, dc, mc, mo, lo, fm, lm, d1, o1, er);
    check("l1_oor_done_cyc", dc, 12);
    check("l1_oor_moves", mc, 2);
    check("l1_oor_err", er, 1'b1);
    check("l1_oor_sticky", sticky, 4'b0010);
    check("l1_oor_tap", tap_of(1), 9'd3);
    oor_vec = '0;

    // Lane 1: LOAD restores INIT_TAP and clears sticky
    run_req(1, 77, 1'b1, 0, dc, mc, mo, lo, fm, lm, d1, o1, er);
    check("l1_load_done_cyc", dc, 2);
    check("l1_load_pulse", lo, 4'b0010);
    check("l1_load_moves", mc, 0);
    check("l1_load_err", er, 1'b0);
    check("l1_load_tap", tap_of(1), 9'd1);
    check("l1_load_sticky", sticky, 4'b0000);

    // Target equals current tap
    run_req(3, 1, 1'b0, 0, dc, mc, mo, lo, fm, lm, d1, o1, er);
    check("eq_done_cyc", dc, 1);
    check("eq_moves", mo, 4'b0000);
    check("eq_err", er, 1'b0);

    // Taps above MAX_TAP are rejected
    run_req(0, 300, 1'b0, 0, dc, mc, mo, lo, fm, lm, d1, o1, er);
    check("tap300_done_cyc", dc, 1);
    check("tap300_err", er, 1'b1);
    check("tap300_moves", mo, 4'b0000);
    check("tap300_tap", tap_of(0), 9'd2);
    run_req(0, 256, 1'b0, 0, dc, mc, mo, lo, fm, lm, d1, o1, er);
    check("tap256_err", {dc[3:0], er}, {4'd1, 1'b1});

    // Lane >= NUM_LANES on the 3-lane instance
    dif3.valid = 1'b1; dif3.lane = 2'd3; dif3.tap = 8'd5;
    tick();
    dif3.valid = 1'b0;
    check("lane3_done", dif3.done, 1'b1);
    check("lane3_err", dif3.rsp_err, 1'b1);
    check("lane3_no_move", mv3, 3'b000);
    tick();
    check("lane3_ready", dif3.ready, 1'b1);
    check("lane3_taps", cur3, {3{8'd1}});

    // Reset in the middle of a step
    dif.valid = 1'b1; dif.lane = 2'd3; dif.tap = 9'd10; dif.load = 1'b0;
    tick();
    dif.valid = 1'b0;
    check("mid_dir", dir_vec, 4'b1000);
    tick();
    check("mid_move", mv_vec, 4'b1000);
    rst_n = 1'b0;
    tick();
    check("mid_rst_move", mv_vec, 4'b0000);
    check("mid_rst_ready", dif.ready, 1'b1);
    check("mid_rst_taps", cur, {4{9'd1}});
    check("mid_rst_done", dif.done, 1'b0);
    check("mid_rst_oe", oe_out, 16'h0000);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      done_seen = done_seen | dif.done;
    end
    check("mid_no_done", done_seen, 1'b0);

    // Fresh request after reset: one step
    run_req(3, 2, 1'b0, 0, dc, mc, mo, lo, fm, lm, d1, o1, er);
    check("post_rst_done_cyc", dc, 7);
    check("post_rst_tap", tap_of(3), 9'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
